// File: rtl/logica_nand_seq_pkg.sv
// Shared definitions for the NAND-sequenced logic unit: opcodes, FSM states,
// mux source/destination codes and the per-opcode pass count.
package logica_nand_seq_pkg;

    typedef enum logic [2:0] {
        OP_NAND  = 3'b000,
        OP_AND   = 3'b001,
        OP_OR    = 3'b010,
        OP_NOR   = 3'b011,
        OP_XOR   = 3'b100,
        OP_XNOR  = 3'b101,
        OP_NOT   = 3'b110,
        OP_PASSA = 3'b111
    } op_t;

    typedef enum logic {
        OCIOSO = 1'b0,
        CALC   = 1'b1
    } estado_t;

    typedef enum logic [2:0] {
        SRC_A = 3'd0,
        SRC_B = 3'd1,
        SRC_T = 3'd2,
        SRC_U = 3'd3,
        SRC_V = 3'd4
    } src_t;

    typedef enum logic [1:0] {
        DST_T = 2'd0,
        DST_U = 2'd1,
        DST_V = 2'd2,
        DST_R = 2'd3
    } dst_t;

    function automatic logic [2:0] n_passos(input op_t op);
        logic [2:0] n;
        case (op)
            OP_NAND:  n = 3'd1;
            OP_AND:   n = 3'd2;
            OP_OR:    n = 3'd3;
            OP_NOR:   n = 3'd4;
            OP_XOR:   n = 3'd4;
            OP_XNOR:  n = 3'd5;
            OP_NOT:   n = 3'd1;
            default:  n = 3'd2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/logica_nand_seq_nand_vetor.sv
// Shared combinational NAND array; the only logic gate the sequencer uses.
module nand_vetor #(
    parameter int LARGURA = 16
) (
    input  logic [LARGURA-1:0] X,
    input  logic [LARGURA-1:0] Y,
    output logic [LARGURA-1:0] Z
);

    assign Z = ~(X & Y);

endmodule

// File: rtl/logica_nand_seq.sv
// Multi-cycle logic unit: decomposes eight bitwise operations into 1-5 passes
// through a single NAND array, using scratch registers T/U/V between passes.
module logica_nand_seq
    import logica_nand_seq_pkg::*;
#(
    parameter int LARGURA = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inicio,
    input  logic [2:0]         op,
    input  logic [LARGURA-1:0] A,
    input  logic [LARGURA-1:0] B,
    output logic               ocupado,
    output logic               pronto,
    output logic [LARGURA-1:0] RESULTADO
);

    estado_t            estado, estado_next;
    logic [2:0]         passo, passo_next;
    logic               pronto_next;
    logic               aceita;
    logic               ultimo;
    op_t                op_reg;
    logic [LARGURA-1:0] a_reg, b_reg;
    logic [LARGURA-1:0] t_reg, u_reg, v_reg;
    src_t               sel_x, sel_y;
    dst_t               dst;
    logic [LARGURA-1:0] x_val, y_val, z_val;

    assign ocupado = (estado == CALC);
    assign ultimo  = (passo == n_passos(op_reg));

    // Schedule table: every opcode writes a scratch register before reading it,
    // so T/U/V never need clearing between operations.
    always_comb begin
        sel_x = SRC_A;
        sel_y = SRC_B;
        dst   = DST_R;
        case (op_reg)
            OP_AND, OP_PASSA: begin
                if (op_reg == OP_PASSA) sel_y = SRC_A;
                if (passo == 3'd1) begin
                    dst = DST_T;
                end else begin
                    sel_x = SRC_T;
                    sel_y = SRC_T;
                end
            end
            OP_OR, OP_NOR: begin
                case (passo)
                    3'd1: begin sel_y = SRC_A; dst = DST_T; end
                    3'd2: begin sel_x = SRC_B; dst = DST_U; end
                    3'd3: begin
                        sel_x = SRC_T;
                        sel_y = SRC_U;
                        dst   = (op_reg == OP_NOR) ? DST_V : DST_R;
                    end
                    default: begin sel_x = SRC_V; sel_y = SRC_V; end
                endcase
            end
            OP_XOR, OP_XNOR: begin
                case (passo)
                    3'd1: dst = DST_T;
                    3'd2: begin sel_y = SRC_T; dst = DST_U; end
                    3'd3: begin sel_x = SRC_B; sel_y = SRC_T; dst = DST_V; end
                    3'd4: begin
                        sel_x = SRC_U;
                        sel_y = SRC_V;
                        dst   = (op_reg == OP_XNOR) ? DST_T : DST_R;
                    end
                    default: begin sel_x = SRC_T; sel_y = SRC_T; end
                endcase
            end
            OP_NOT:  sel_y = SRC_A;
            default: ;
        endcase
    end

    always_comb begin
        case (sel_x)
            SRC_B:   x_val = b_reg;
            SRC_T:   x_val = t_reg;
            SRC_U:   x_val = u_reg;
            SRC_V:   x_val = v_reg;
            default: x_val = a_reg;
        endcase
        case (sel_y)
            SRC_A:   y_val = a_reg;
            SRC_T:   y_val = t_reg;
            SRC_U:   y_val = u_reg;
            SRC_V:   y_val = v_reg;
            default: y_val = b_reg;
        endcase
    end

    nand_vetor #(.LARGURA(LARGURA)) u_nand (
        .X(x_val),
        .Y(y_val),
        .Z(z_val)
    );

    always_comb begin
        estado_next = estado;
        passo_next  = passo;
        pronto_next = 1'b0;
        aceita      = 1'b0;
        case (estado)
            OCIOSO: begin
                if (inicio) begin
                    aceita      = 1'b1;
                    estado_next = CALC;
                    passo_next  = 3'd1;
                end
            end
            default: begin
                if (ultimo) begin
                    estado_next = OCIOSO;
                    passo_next  = 3'd0;
                    pronto_next = 1'b1;
                end else begin
                    passo_next = passo + 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= OCIOSO;
            passo     <= 3'd0;
            pronto    <= 1'b0;
            RESULTADO <= '0;
            t_reg     <= '0;
            u_reg     <= '0;
            v_reg     <= '0;
        end else begin
            estado <= estado_next;
            passo  <= passo_next;
            pronto <= pronto_next;
            if (estado == CALC) begin
                case (dst)
                    DST_T:   t_reg     <= z_val;
                    DST_U:   u_reg     <= z_val;
                    DST_V:   v_reg     <= z_val;
                    default: RESULTADO <= z_val;
                endcase
            end
        end
    end

    // Operands are only meaningful once accepted, so they carry no reset.
    always_ff @(posedge clk) begin
        if (aceita && !rst) begin
            a_reg  <= A;
            b_reg  <= B;
            op_reg <= op_t'(op);
        end
    end

endmodule

// File: tb/tb_logica_nand_seq.sv
// Directed + randomized bench for logica_nand_seq against a truth-level model.
module tb_logica_nand_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         inicio;
    logic [2:0]   op;
    logic [W-1:0] A, B;
    logic         ocupado, pronto;
    logic [W-1:0] RESULTADO;

    int n_chk  = 0;
    int n_pass = 0;

    logica_nand_seq #(.LARGURA(W)) dut (
        .clk(clk),
        .rst(rst),
        .inicio(inicio),
        .op(op),
        .A(A),
        .B(B),
        .ocupado(ocupado),
        .pronto(pronto),
        .RESULTADO(RESULTADO)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            3'd0:    return ~(a & b);
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o);
        int lat [8] = '{1, 2, 3, 4, 4, 5, 1, 2};
        return lat[o];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        inicio = 1'b1;
        op     = o;
        A      = a;
        B      = b;
        tick();
        inicio = 1'b0;
        op     = 3'($urandom);
        A      = W'($urandom);
        B      = W'($urandom);
        k = 0;
        while (pronto !== 1'b1 && k < 8) begin
            chk({tag, "_busy"}, 32'(ocupado), 32'd1);
            tick();
            k++;
        end
        chk({tag, "_lat"}, 32'(k), 32'(ref_lat(o)));
        chk({tag, "_res"}, 32'(RESULTADO), 32'(ref_result(o, a, b)));
        chk({tag, "_idle"}, 32'(ocupado), 32'd0);
        tick();
        chk({tag, "_pulse"}, 32'(pronto), 32'd0);
    endtask

    initial begin
        int k;
        int n_pronto;
        logic [W-1:0] capt;
        logic [W-1:0] hold_val;
        logic [2:0] seq_op;

        rst    = 1'b1;
        inicio = 1'b0;
        op     = 3'd0;
        A      = '0;
        B      = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_res", 32'(RESULTADO), 32'd0);
        chk("reset_busy", 32'(ocupado), 32'd0);
        chk("reset_pronto", 32'(pronto), 32'd0);

        for (int o = 0; o < 8; o++) begin
            run_op($sformatf("op%0d", o), 3'(o), 16'hF0F0, 16'hFF00);
        end

        // Abandon an XOR mid-flight; rst also overrides a simultaneous inicio.
        inicio = 1'b1;
        op     = 3'd4;
        A      = 16'hF0F0;
        B      = 16'hFF00;
        tick();
        inicio = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        inicio = 1'b1;
        tick();
        rst    = 1'b0;
        inicio = 1'b0;
        chk("midrst_res", 32'(RESULTADO), 32'd0);
        chk("midrst_busy", 32'(ocupado), 32'd0);
        chk("midrst_pronto", 32'(pronto), 32'd0);
        n_pronto = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pronto === 1'b1) n_pronto++;
        end
        chk("midrst_no_pronto", 32'(n_pronto), 32'd0);
        run_op("after_rst_nand", 3'd0, 16'hF0F0, 16'hFF00);

        // inicio pulses during CALC must be ignored.
        inicio = 1'b1;
        op     = 3'd5;
        A      = 16'hF0F0;
        B      = 16'hFF00;
        tick();
        inicio = 1'b0;
        n_pronto = 0;
        capt = '0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 2 || i == 3) begin
                inicio = 1'b1;
                op     = 3'd0;
                A      = W'($urandom);
                B      = W'($urandom);
            end else begin
                inicio = 1'b0;
            end
            tick();
            if (pronto === 1'b1) begin
                n_pronto++;
                capt = RESULTADO;
            end
        end
        chk("busy_one_pronto", 32'(n_pronto), 32'd1);
        chk("busy_res", 32'(capt), 32'hF00F);
        chk("busy_idle", 32'(ocupado), 32'd0);

        // Back-to-back: accept edge plus N passes between consecutive pulses.
        inicio = 1'b1;
        A      = 16'h00FF;
        B      = 16'h0F0F;
        for (int i = 0; i < 6; i++) begin
            seq_op = (i % 2 == 0) ? 3'd1 : 3'd2;
            op = seq_op;
            k = 0;
            do begin
                tick();
                k++;
                chk("b2b_excl", 32'(pronto & ocupado), 32'd0);
            end while (pronto !== 1'b1 && k < 10);
            chk($sformatf("b2b_gap%0d", i), 32'(k), 32'(ref_lat(seq_op) + 1));
            chk($sformatf("b2b_res%0d", i), 32'(RESULTADO), 32'(ref_result(seq_op, 16'h00FF, 16'h0F0F)));
        end
        inicio = 1'b0;
        tick();
        chk("b2b_stop", 32'(ocupado), 32'd0);

        run_op("ext_xor", 3'd4, 16'hFFFF, 16'hFFFF);
        run_op("ext_xnor", 3'd5, 16'h0000, 16'hFFFF);
        run_op("ext_not", 3'd6, 16'h0000, 16'h1234);

        hold_val = RESULTADO;
        for (int i = 0; i < 10; i++) begin
            A  = W'($urandom);
            B  = W'($urandom);
            op = 3'($urandom);
            tick();
            chk("hold_res", 32'(RESULTADO), 32'(hold_val));
            chk("hold_pronto", 32'(pronto), 32'd0);
            chk("hold_busy", 32'(ocupado), 32'd0);
        end

        for (int i = 0; i < 24; i++) begin
            run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
